// File: rtl/hex_scan_driver_pkg.sv
// Shared types and helpers for the multiplexed hex display scan driver.
// Holds the slot-phase enum and the digit-select polarity mapping.
package hex_scan_driver_pkg;

    // ST_GUARD: all digits dark while the previous digit's segments settle.
    typedef enum logic {
        ST_GUARD = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_e;

    // Electrical level for one digit-select line, given the logical "on".
    function automatic logic sel_level(input logic on, input logic active_low);
        return on ^ active_low;
    endfunction

endpackage

// File: rtl/hex_scan_driver.sv
// Time-multiplexed scan driver feeding a hex-to-7-segment decoder.
// Frame-synchronous value update, per-slot dead time, optional leading-zero blanking.
module hex_scan_driver
    import hex_scan_driver_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int GUARD          = 2,
    parameter bit SEL_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    blank_lz,
    output logic [3:0]              dig_val,
    output logic                    dig_en,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_tick
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;

    logic [4*NUM_DIGITS-1:0] shadow;
    logic [4*NUM_DIGITS-1:0] disp;
    logic                    pending;
    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    scan_state_e             state;
    scan_state_e             state_next;

    logic                    cnt_last;
    logic                    idx_last;
    logic                    boundary;
    logic [3:0]              cur_nib;
    logic                    blank_cur;
    logic [NUM_DIGITS-1:0]   sel_d;
    logic                    en_d;

    assign cnt_last = (cnt == CW'(SCAN_DIV - 1));
    assign idx_last = (idx == IW'(NUM_DIGITS - 1));
    assign boundary = cnt_last & idx_last;
    assign cur_nib  = disp[4*idx +: 4];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_GUARD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        blank_cur  = blank_lz && (idx != '0);
        sel_d      = '0;
        en_d       = 1'b0;

        case (state)
            ST_GUARD: if (cnt == CW'(GUARD - 1)) state_next = ST_SHOW;
            ST_SHOW:  if (cnt_last)              state_next = ST_GUARD;
            default:                             state_next = ST_GUARD;
        endcase

        // A digit is a leading zero only if it and every digit above it are zero.
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((i >= int'(idx)) && (disp[4*i +: 4] != 4'h0)) blank_cur = 1'b0;
        end

        for (int i = 0; i < NUM_DIGITS; i++) begin
            sel_d[i] = sel_level((state == ST_SHOW) && (int'(idx) == i), SEL_ACTIVE_LOW);
        end
        en_d = (state == ST_SHOW) && !blank_cur;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow     <= '0;
            disp       <= '0;
            pending    <= 1'b0;
            cnt        <= '0;
            idx        <= '0;
            dig_val    <= 4'h0;
            dig_en     <= 1'b0;
            dig_sel    <= {NUM_DIGITS{sel_level(1'b0, SEL_ACTIVE_LOW)}};
            frame_tick <= 1'b0;
        end else begin
            if (cnt_last) begin
                cnt <= '0;
                idx <= idx_last ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            // A load coinciding with the boundary stays pending for the next frame.
            if (boundary && pending) disp <= shadow;
            if (load) begin
                shadow  <= value;
                pending <= 1'b1;
            end else if (boundary) begin
                pending <= 1'b0;
            end

            dig_val    <= cur_nib;
            dig_en     <= en_d;
            dig_sel    <= sel_d;
            frame_tick <= boundary;
        end
    end

endmodule

// File: tb/tb_hex_scan_driver.sv
// Directed bench for hex_scan_driver with NUM_DIGITS=4, SCAN_DIV=8, GUARD=2, active-low selects.
// Each frame is checked cycle by cycle against hand-derived slot expectations.
module tb_hex_scan_driver;

    localparam int N  = 4;
    localparam int SD = 8;
    localparam int GD = 2;

    logic          clk;
    logic          rst;
    logic          load;
    logic [4*N-1:0] value;
    logic          blank_lz;
    logic [3:0]    dig_val;
    logic          dig_en;
    logic [N-1:0]  dig_sel;
    logic          frame_tick;

    int checks   = 0;
    int failures = 0;

    hex_scan_driver #(
        .NUM_DIGITS     (N),
        .SCAN_DIV       (SD),
        .GUARD          (GD),
        .SEL_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .value      (value),
        .blank_lz   (blank_lz),
        .dig_val    (dig_val),
        .dig_en     (dig_en),
        .dig_sel    (dig_sel),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int j, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, j, got, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_sel"},  0, 16'(dig_sel),    16'h000F);
        chk({tag, "_en"},   0, 16'(dig_en),     16'h0000);
        chk({tag, "_val"},  0, 16'(dig_val),    16'h0000);
        chk({tag, "_tick"}, 0, 16'(frame_tick), 16'h0000);
    endtask

    // Steps through one frame (or its first `steps` cycles), optionally pulsing
    // load at positions la/lb, and checks all outputs for the displayed value.
    task automatic run_frame(input string tag, input logic [15:0] exp_disp, input logic blk,
                             input int steps, input int la, input logic [15:0] lv,
                             input int lb, input logic [15:0] lbv);
        int         slot;
        int         d;
        logic [3:0] exp_sel;
        logic       exp_en;
        logic [3:0] exp_val;
        logic       exp_tick;
        logic [15:0] upper;
        blank_lz = blk;
        for (int j = 0; j < steps; j++) begin
            load = 1'b0;
            if (j == la) begin load = 1'b1; value = lv;  end
            if (j == lb) begin load = 1'b1; value = lbv; end
            @(posedge clk);
            #1;
            slot     = j % SD;
            d        = j / SD;
            upper    = exp_disp >> (4 * d);
            exp_val  = upper[3:0];
            exp_sel  = (slot < GD) ? 4'b1111 : ~(4'b0001 << d);
            exp_en   = (slot >= GD) && !(blk && (d != 0) && (upper == 16'h0));
            exp_tick = (j == N * SD - 1);
            chk({tag, "_sel"},  j, 16'(dig_sel),    16'(exp_sel));
            chk({tag, "_en"},   j, 16'(dig_en),     16'(exp_en));
            chk({tag, "_val"},  j, 16'(dig_val),    16'(exp_val));
            chk({tag, "_tick"}, j, 16'(frame_tick), 16'(exp_tick));
        end
        load = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        load     = 1'b0;
        value    = '0;
        blank_lz = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        rst = 1'b0;

        // Reset release, idle frame, then a load whose value appears one frame later.
        run_frame("f0_idle", 16'h0000, 1'b0, 32, -1, 16'h0, -1, 16'h0);
        run_frame("f1_load", 16'h0000, 1'b0, 32,  0, 16'h12AF, -1, 16'h0);
        run_frame("f2_12af", 16'h12AF, 1'b0, 32, -1, 16'h0, -1, 16'h0);

        // Leading-zero blanking on and off.
        run_frame("f3_lz",   16'h12AF, 1'b1, 32,  5, 16'h0030, -1, 16'h0);
        run_frame("f4_blk",  16'h0030, 1'b1, 32, -1, 16'h0, -1, 16'h0);
        run_frame("f5_noblk",16'h0030, 1'b0, 32, -1, 16'h0, -1, 16'h0);

        // Two loads in one frame: the later one wins.
        run_frame("f6_2ld",  16'h0030, 1'b0, 32,  3, 16'h1111, 20, 16'h2222);
        run_frame("f7_2222", 16'h2222, 1'b0, 32, -1, 16'h0, -1, 16'h0);

        // Load landing on the frame-boundary cycle is deferred one frame.
        run_frame("f8_bnd",  16'h2222, 1'b0, 32,  4, 16'h4444, 31, 16'h3333);
        run_frame("f9_4444", 16'h4444, 1'b0, 32, -1, 16'h0, -1, 16'h0);
        run_frame("f10_3333",16'h3333, 1'b0, 32, -1, 16'h0, -1, 16'h0);

        // Reset during digit 2's SHOW slot with a pending value, which must be lost.
        run_frame("f11_part",16'h3333, 1'b0, 20,  1, 16'h5555, -1, 16'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_outputs("mid_rst");
        rst = 1'b0;
        run_frame("r0_zero", 16'h0000, 1'b0, 32, -1, 16'h0, -1, 16'h0);
        run_frame("r1_zero", 16'h0000, 1'b0, 32, -1, 16'h0, -1, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hex_scan_driver.md
Name: hex_scan_driver

Overview:
Time-multiplexed scan driver for an N-digit common-segment 7-segment display; sits directly upstream of the team's 4-bit hex-to-7-segment decoder.
Latches a packed hex value and walks digit by digit, presenting one nibble plus an enable to the decoder while asserting the matching digit select.
Provides frame-synchronous value update (no tearing), a dead-time guard between digits (anti-ghosting) and optional leading-zero blanking.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8)
SCAN_DIV, 50000, clock cycles per digit slot (must be > GUARD)
GUARD, 2, cycles at the start of each slot with all digits off
SEL_ACTIVE_LOW, 1, 1 = dig_sel active-low (common-anode), 0 = active-high

Ports:
clk  in  1  system clock; single clock domain
rst  in  1  synchronous, active-high reset
load  in  1  one-cycle strobe; captures value into shadow register
value  in  4*NUM_DIGITS  packed hex digits; nibble i = digit i (digit 0 = rightmost)
blank_lz  in  1  1 = blank leading zeros
dig_val  out  4  nibble to decoder "in"
dig_en  out  1  to decoder "en"; 0 forces segments off
dig_sel  out  NUM_DIGITS  one-hot digit select (polarity per SEL_ACTIVE_LOW)
frame_tick  out  1  one-cycle pulse on the last cycle of each frame

Behaviour:
- All outputs registered. Reset: dig_val=0, dig_en=0, dig_sel all inactive, frame_tick=0. Internally shadow=0, disp=0, pending=0, idx=0, cnt=0, state=GUARD.
- Slot counter cnt counts 0..SCAN_DIV-1, then wraps to 0 and advances idx. idx counts 0..NUM_DIGITS-1, then wraps to 0.
- FSM states:
  - GUARD (cnt < GUARD): dig_sel all inactive, dig_en=0, dig_val=disp[idx].
  - SHOW (cnt >= GUARD): dig_sel asserts bit idx only, dig_val=disp[idx], dig_en = ~blank(idx).
  - Transition GUARD->SHOW when cnt reaches GUARD. SHOW->GUARD on cnt wrap.
- Output registers reflect the state/cnt/idx of the previous cycle (1-cycle latency). The first SHOW output appears at cycle GUARD+1 after reset release.
- blank(i) = blank_lz & (i != 0) & (disp nibbles i..NUM_DIGITS-1 all zero). Digit 0 is never blanked, so value 0 shows "0". Blanking uses disp, not shadow.
- load: shadow <= value; pending <= 1.
- Frame boundary = cycle where cnt==SCAN_DIV-1 and idx==NUM_DIGITS-1:
  - frame_tick=1 on the following output cycle.
  - If pending, disp <= shadow and pending <= 0.
  - Simultaneous load at the boundary: disp takes the old shadow; shadow takes the new value; pending stays 1 and the new value transfers at the next boundary.
- Multiple loads within one frame: the last one wins.
- rst mid-frame: the next cycle is the full reset state; any pending value is discarded.
- blank_lz is sampled every cycle, with no frame sync.

Decomposition:
- Shared package: state enum {GUARD, SHOW}, and a helper function for the digit-select polarity.
- No sub-modules. The slot counter and idx counter stay inline.
- Top-level display wrapper instantiates hex_scan_driver followed by the existing hex-to-7-segment decoder.

Test Plan:
All scenarios use NUM_DIGITS=4, SCAN_DIV=8, GUARD=2, SEL_ACTIVE_LOW=1.
1. Reset release, no load -> dig_sel=4'b1111, dig_en=0 for cycles 1-2. From cycle 3: dig_sel=4'b1110, dig_val=0, dig_en=1. frame_tick first pulses at cycle 32.
2. load value=16'h12AF, then run two frames -> frame 1 still shows 0. Frame 2 shows F,A,2,1 on sel 1110,1101,1011,0111, each for 6 cycles, with 2 all-off cycles between digits.
3. value=16'h0030, blank_lz=1 -> digits 0 and 1 have dig_en=1 (val 0, 3); digits 2 and 3 have dig_en=0. With blank_lz=0, all four are enabled.
4. load 16'h1111 mid-frame, then load 16'h2222 in the same frame -> next frame shows 2222 only; 1111 is never displayed.
5. load 16'h3333 exactly on the frame-boundary cycle while shadow holds 16'h4444 -> next frame shows 4444, the frame after shows 3333.
6. Assert rst for 1 cycle during a SHOW slot of digit 2 with pending set -> next cycle: outputs at reset values, idx=0, display shows 0 and the pending value is lost.
